// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage. Owns the program counter and drives the
// combinational read address of the instruction memory. Each returned word is
// captured in a single-entry output register that decode drains through a
// valid/ready handshake.
//
// Control flow handled here:
//   - `j` is resolved in the cycle it is fetched, so the next entry is the
//     jump target with no bubble.
//   - Branch redirects from execute take one bubble. They discard the held
//     entry and clear a halt.
//   - The self-loop terminator (HALT_WORD) is delivered to decode. Fetching
//     then stops until a redirect or reset.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   imem_addr      word address presented to the instruction memory (= pc)
//   imem_data      memory read data, valid combinationally with imem_addr
//   redirect_valid one-cycle taken-branch pulse from execute
//   redirect_pc    redirect target word address
//   out_valid      output register holds an instruction
//   out_ready      decode accepts the held entry this cycle
//   out_instr      held instruction word
//   out_pc         word address of out_instr
//   halted         halt word fetched; no further fetches
//   fetch_count    number of completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_WORD = 32'h6000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [5:0] OP_J = 6'b000010;

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        handshake;
  logic        load;
  logic        is_jump;
  logic        is_halt;

  assign imem_addr = pc;

  // Decode takes the held entry this cycle.
  assign handshake = out_valid && out_ready;

  // The output register can take a new word when it is empty or is being
  // drained in the same cycle. A redirect suppresses the load because the
  // word on imem_data belongs to the path being abandoned.
  assign load = !halted && !redirect_valid && (!out_valid || out_ready);

  assign is_jump = (imem_data[31:26] == OP_J);
  assign is_halt = (imem_data == HALT_WORD);

  // Sequential successor of the word being fetched. A jump keeps the top six
  // PC bits and replaces the rest with the 26-bit target field. The halt word
  // parks the PC on itself.
  always_comb begin
    // NOTE: assigning a default before any condition keeps this purely
    // combinational; a path that skipped next_pc would infer a latch.
    next_pc = pc + 32'd1;
    if (is_jump) begin
      next_pc = {pc[31:26], imem_data[25:0]};
    end else if (is_halt) begin
      next_pc = pc;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would let later statements see
  // already-updated state and create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= 32'd0;
      out_pc      <= 32'd0;
      halted      <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      // Counted even when a redirect lands in the same cycle: decode still
      // consumed the entry before it was discarded.
      if (handshake) begin
        fetch_count <= fetch_count + 32'd1;
      end

      if (redirect_valid) begin
        pc        <= redirect_pc;
        out_valid <= 1'b0;
        halted    <= 1'b0;
      end else if (load) begin
        out_instr <= imem_data;
        out_pc    <= pc;
        out_valid <= 1'b1;
        pc        <= next_pc;
        // Halt rises on the same edge that registers the halt word, so
        // decode sees both together. A jump encoding always wins.
        if (is_halt && !is_jump) begin
          halted <= 1'b1;
        end
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the `Text` instruction memory and downstream-feeding the decode stage. It owns the program counter, drives the memory's combinational read address, and latches each returned word into a single-entry output register with a valid/ready handshake. It resolves `j` locally without a bubble, accepts branch redirects from execute, and stops fetching on the program's self-loop halt word.

## Interface
Parameters:
- `RESET_PC`, default `32'd0`: word address loaded into the PC on reset.
- `HALT_WORD`, default `32'h60000000`: encoding of `beq $0,$0,0`, the program terminator.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_addr`  out  32  PC value, wired to `Text.r_addr`.
- `imem_data`  in  32  `Text.dout`, valid combinationally in the same cycle as `imem_addr`.
- `redirect_valid`  in  1  taken branch from execute, one-cycle pulse.
- `redirect_pc`  in  32  redirect target word address.
- `out_valid`  out  1  output register holds an instruction.
- `out_ready`  in  1  decode accepts the entry this cycle.
- `out_instr`  out  32  fetched instruction word.
- `out_pc`  out  32  word address of `out_instr`.
- `halted`  out  1  halt word fetched; fetching stopped.
- `fetch_count`  out  32  number of completed output handshakes.

## Operation
- All addresses are word addresses. Sequential next PC is `pc + 1`, with 32-bit wrap (`32'hFFFFFFFF` -> `0`).
- `imem_addr = pc`, combinational from the PC register.
- `load = !halted && !redirect_valid && (!out_valid || out_ready)`.
- On `load`:
  - `out_instr <= imem_data`, `out_pc <= pc`, `out_valid <= 1`.
  - Next PC:
    - if `imem_data[31:26] == 6'b000010` (`j`): `pc <= {pc[31:26], imem_data[25:0]}`.
    - else if `imem_data == HALT_WORD`: `pc` unchanged, `halted <= 1`.
    - else: `pc <= pc + 1`.
- No load and no redirect, with `out_valid && out_ready`: `out_valid <= 0`.
- `redirect_valid` has priority over everything except reset:
  - `pc <= redirect_pc`, `out_valid <= 0` (the held entry is discarded), `halted <= 0`.
  - No load occurs in that cycle.
- `fetch_count` increments, with wrap, on every cycle with `out_valid && out_ready`, including a cycle coincident with a redirect.
- Branches (`beq` `6'b011000`, `ble` `6'b011110`) are not interpreted here. Fetch continues sequentially; execute issues the redirect.
- While `halted`, the held entry still drains normally. After the drain, `out_valid` stays 0 until a redirect or reset.

## Timing
- Reset values: `pc = RESET_PC` (so `imem_addr = RESET_PC`), `out_valid = 0`, `out_instr = 0`, `out_pc = 0`, `halted = 0`, `fetch_count = 0`. Reset during any activity, including mid-stall or while halted, restores all of these on the next edge.
- Latency: the word at PC `p` appears on `out_*` one cycle after `imem_addr = p`.
- Throughput: 1 instruction/cycle while `out_ready = 1`.
- Jump: zero bubble. The entry following the `j` has `out_pc` equal to the jump target.
- Redirect: 1 bubble. In the cycle after the pulse, `out_valid = 0` and `imem_addr = redirect_pc`. The target instruction is valid on the cycle after that.
- Backpressure: while `out_valid && !out_ready`, all of `out_*`, `pc` and `fetch_count` hold steady.
- Handshake rule: `out_instr` and `out_pc` never change while `out_valid && !out_ready`, except on redirect or reset.
- Halt: `halted` rises in the same edge that registers the halt word in `out_instr`.

## Test plan
- Reset then `out_ready = 1`, `Text` bubble-sort program loaded: successive entries are `out_pc` 0,1,2 with `out_instr` `32'h00808020`, `32'h00a08820`, `32'h2232ffff`; `fetch_count = 3` after the third handshake.
- Jump: `out_pc = 13` holds `32'h08000005`; the next entry is `out_pc = 5`, `out_instr = 32'h60530009`, with no invalid cycle between them.
- Backpressure: `out_ready = 0` for 3 cycles while `out_pc = 6`. `out_instr` holds `32'h02134020`, `imem_addr` holds 7, `fetch_count` is frozen. After `out_ready` rises, `out_pc = 7`, `out_instr = 32'h8d140000`.
- Redirect to halt: pulse `redirect_valid` with `redirect_pc = 16` while `out_pc = 4` is held.
  - Next cycle: `out_valid = 0`, `imem_addr = 16`.
  - Then `out_pc = 16`, `out_instr = 32'h60000000`, `halted = 1`, and `imem_addr` stays 16.
  - After that handshake, `out_valid` stays 0 for 10 or more cycles.
- Redirect while halted with `redirect_pc = 0`: `halted` clears next cycle and the fetch sequence restarts at `out_pc = 0`.
- Simultaneous events: redirect in the same cycle as `out_valid && out_ready`, then `rst` asserted mid-stream. `fetch_count` increments once for the coincident handshake; `rst` then restores every reset value listed in Timing.
